// File: rtl/ma_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: result-select
// encodings, load/store size codes, the stage FSM state type and an
// access-legality helper.
package ma_stage_pkg;

    // Write-back result select encodings
    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [1:0] SEL_EXT  = 2'b11;

    // Access size / sign codes (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } ma_state_e;

    // An access is legal when its size code exists and the address is
    // naturally aligned for that size.
    function automatic logic access_legal(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~addr_lo[0];
            F3_LW:         ok = (addr_lo == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ma_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the
// data memory (slave).
interface ma_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_rdata, dm_ack
    );
endinterface

// File: rtl/lsu_align.sv
// Lane steering for the memory-access stage: store byte enables and
// replicated write data, plus load lane selection and sign/zero extension.
module lsu_align
    import ma_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Pick the addressed byte and halfword out of the read word
    always_comb begin
        ld_byte_s = 8'h00;
        case (addr_lo)
            2'b00:   ld_byte_s = ld_raw[7:0];
            2'b01:   ld_byte_s = ld_raw[15:8];
            2'b10:   ld_byte_s = ld_raw[23:16];
            2'b11:   ld_byte_s = ld_raw[31:24];
            default: ld_byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            ld_half_s = ld_raw[31:16];
        end else begin
            ld_half_s = ld_raw[15:0];
        end
    end

    // Store lanes: narrow data is replicated so any lane can take it
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = 32'h0000_0000;
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                if (addr_lo[1]) begin
                    st_be = 4'b1100;
                end else begin
                    st_be = 4'b0011;
                end
                st_wdata = {2{st_data[15:0]}};
            end
            2'b10: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
            default: begin
                st_be    = 4'b0000;
                st_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Load extension by size/sign code
    always_comb begin
        ld_data = 32'h0000_0000;
        case (funct3)
            F3_LB:   ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_LH:   ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            F3_LW:   ld_data = ld_raw;
            F3_LBU:  ld_data = {24'h00_0000, ld_byte_s};
            F3_LHU:  ld_data = {16'h0000, ld_half_s};
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/ma_stage.sv
// Memory-access pipeline stage. Non-memory instructions pass to the
// write-back registers in one cycle; legal loads/stores run a
// request/ack transaction on the data bus (IDLE -> BUSY -> DONE) while
// stalling upstream. Illegal accesses never reach the bus and retire
// with a one-cycle misalign pulse.
module ma_stage
    import ma_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] M_alu_o,
    input  logic [31:0] M_dm_wd,
    input  logic [31:0] M_ext,
    input  logic [31:0] M_pc_p4,
    input  logic [4:0]  M_rf_a3,
    input  logic [2:0]  M_funct3,
    input  logic        M_we_rf,
    input  logic        M_we_dm,
    input  logic [1:0]  M_sel_result,
    ma_stage_if.master  dm,
    output logic [31:0] W_result,
    output logic [4:0]  W_rf_a3,
    output logic        W_we_rf,
    output logic        ma_stall,
    output logic        ma_misalign
);

    ma_state_e   state_q, state_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] load_buf_q, load_buf_d;
    logic [31:0] w_result_q, w_result_d;
    logic [4:0]  w_rf_a3_q, w_rf_a3_d;
    logic        w_we_rf_q, w_we_rf_d;
    logic        misalign_q, misalign_d;

    logic        mem_op_s;
    logic        mem_legal_s;
    logic        mem_illegal_s;
    logic        wb_we_s;
    logic [31:0] result_s;
    logic [3:0]  st_be_s;
    logic [31:0] st_wdata_s;
    logic [31:0] ld_data_s;

    lsu_align u_lsu_align (
        .funct3   (M_funct3),
        .addr_lo  (M_alu_o[1:0]),
        .st_data  (M_dm_wd),
        .ld_raw   (dm.dm_rdata),
        .st_be    (st_be_s),
        .st_wdata (st_wdata_s),
        .ld_data  (ld_data_s)
    );

    // Classify the instruction; a store wins over a load select
    always_comb begin
        mem_op_s      = M_we_dm | (M_sel_result == SEL_LOAD);
        mem_legal_s   = mem_op_s & access_legal(M_funct3, M_alu_o[1:0]);
        mem_illegal_s = mem_op_s & ~access_legal(M_funct3, M_alu_o[1:0]);
        wb_we_s       = M_we_rf & ~M_we_dm & ~mem_illegal_s & (M_rf_a3 != 5'd0);
    end

    // Write-back result select
    always_comb begin
        result_s = M_alu_o;
        case (M_sel_result)
            SEL_ALU:  result_s = M_alu_o;
            SEL_LOAD: result_s = load_buf_q;
            SEL_PC4:  result_s = M_pc_p4;
            SEL_EXT:  result_s = M_ext;
            default:  result_s = M_alu_o;
        endcase
    end

    // Upstream freeze: pending legal access in IDLE, or waiting for ack
    always_comb begin
        if (rst) begin
            ma_stall = 1'b0;
        end else if (state_q == ST_BUSY) begin
            ma_stall = 1'b1;
        end else if (state_q == ST_IDLE) begin
            ma_stall = mem_legal_s;
        end else begin
            ma_stall = 1'b0;
        end
    end

    // Next-state and next-output computation for the stage FSM
    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_be_d    = dm_be_q;
        load_buf_d = load_buf_q;
        w_result_d = w_result_q;
        w_rf_a3_d  = w_rf_a3_q;
        w_we_rf_d  = w_we_rf_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_legal_s) begin
                    state_d    = ST_BUSY;
                    dm_req_d   = 1'b1;
                    dm_we_d    = M_we_dm;
                    dm_addr_d  = {M_alu_o[31:2], 2'b00};
                    dm_wdata_d = st_wdata_s;
                    dm_be_d    = st_be_s;
                end else begin
                    w_result_d = result_s;
                    w_rf_a3_d  = M_rf_a3;
                    w_we_rf_d  = wb_we_s;
                    misalign_d = mem_illegal_s;
                end
            end
            ST_BUSY: begin
                if (dm.dm_ack) begin
                    state_d    = ST_DONE;
                    dm_req_d   = 1'b0;
                    load_buf_d = ld_data_s;
                end else begin
                    state_d    = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                w_result_d = result_s;
                w_rf_a3_d  = M_rf_a3;
                w_we_rf_d  = wb_we_s;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= 32'h0000_0000;
            dm_wdata_q <= 32'h0000_0000;
            dm_be_q    <= 4'b0000;
            load_buf_q <= 32'h0000_0000;
            w_result_q <= 32'h0000_0000;
            w_rf_a3_q  <= 5'd0;
            w_we_rf_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_be_q    <= dm_be_d;
            load_buf_q <= load_buf_d;
            w_result_q <= w_result_d;
            w_rf_a3_q  <= w_rf_a3_d;
            w_we_rf_q  <= w_we_rf_d;
            misalign_q <= misalign_d;
        end
    end

    assign dm.dm_req    = dm_req_q;
    assign dm.dm_we     = dm_we_q;
    assign dm.dm_addr   = dm_addr_q;
    assign dm.dm_wdata  = dm_wdata_q;
    assign dm.dm_be     = dm_be_q;
    assign W_result     = w_result_q;
    assign W_rf_a3      = w_rf_a3_q;
    assign W_we_rf      = w_we_rf_q;
    assign ma_misalign  = misalign_q;

endmodule
